// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction-fetch front end of the four-stage pipeline (FETCH, READ, EXEC, WB).
// It owns the program counter and drives the instruction-memory address.
// It offers the fetched word to IR1.
// It keeps a PC history aligned with IR1..IR3, so a branch resolved in EXEC
// can compute its target from the PC of the branch instruction itself.
// When STOP is fetched, the PC is held while the pipeline drains.
// A cycle counter runs from reset release until STOP retires in WB.
// The branch offset is taken from ir3[7:4], so PC_WIDTH is expected to be at
// least 4.

module fetch_sequencer #(
  parameter int                  PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 branch,
  input  logic                 ir1_load,
  input  logic [7:0]           ir3,
  input  logic [7:0]           ir4,
  input  logic                 en_wb,
  input  logic [7:0]           mem_data,
  output logic [PC_WIDTH-1:0]  mem_addr,
  output logic [7:0]           instr_out,
  output logic [PC_WIDTH-1:0]  pc3,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  // Opcode of the STOP instruction, found in the low nibble of a word.
  localparam logic [3:0] STOP_OP = 4'h1;

  // RUN fetches normally.
  // DRAIN freezes the PC while the STOP word moves down the pipe.
  // HALT is terminal until reset.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [PC_WIDTH-1:0]   pc1_q;
  logic [PC_WIDTH-1:0]   pc2_q;
  logic [PC_WIDTH-1:0]   pc3_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic signed [3:0]     brOffset;
  logic [PC_WIDTH-1:0]   branchTarget;
  logic [PC_WIDTH-1:0]   pcIncr;
  logic                  fetchStop;
  logic                  retireStop;
  logic                  histShift;
  logic                  cntEn;

  // Decode helpers.
  // The branch target is relative to the PC of the branch instruction,
  // which is the instruction now sitting in EXEC (pc3).
  // The 4-bit offset is sign-extended by the sized cast.
  // All PC arithmetic wraps modulo 2^PC_WIDTH.
  always_comb begin
    brOffset     = ir3[7:4];
    branchTarget = pc3_q + PC_WIDTH'(1) + PC_WIDTH'(brOffset);
    pcIncr       = pc_q + PC_WIDTH'(1);
    fetchStop    = ir1_load && (mem_data[3:0] == STOP_OP);
    retireStop   = en_wb && (ir4[3:0] == STOP_OP);
  end

  // State register: the FSM state and the fetch PC.
  // A synchronous reset puts both back to their starting point,
  // even if the pipeline is in the middle of a drain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic.
  // A taken branch in EXEC beats everything else in both RUN and DRAIN.
  // In DRAIN, a taken branch means the STOP was in the branch shadow,
  // so fetch resumes at the target.
  // The STOP-in-WB retire check only matters in DRAIN.
  // HALT ignores every input.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      RUN: begin
        if (branch) begin
          pc_d = branchTarget;
        end else if (fetchStop) begin
          state_d = DRAIN;
        end else if (ir1_load) begin
          pc_d = pcIncr;
        end
      end
      DRAIN: begin
        if (branch) begin
          pc_d    = branchTarget;
          state_d = RUN;
        end else if (retireStop) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // Output and enable logic.
  // The memory address is simply the PC.
  // The memory word passes straight through to IR1. While draining, the PC
  // is frozen on the STOP word, so repeated IR1 loads are harmless.
  // The counter skips the edge on which HALT is entered, so its final value
  // excludes the retire edge.
  always_comb begin
    mem_addr    = pc_q;
    instr_out   = mem_data;
    pc3         = pc3_q;
    halted      = (state_q == HALT);
    cycle_count = cnt_q;
    histShift   = ir1_load && (state_q != HALT);
    cntEn       = (state_q != HALT) && (state_d != HALT);
  end

  // PC history.
  // It shifts with the same enable as IR1, so pc1..pc3 stay aligned with
  // the instructions in IR1..IR3.
  // It is frozen once halted.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc1_q <= '0;
      pc2_q <= '0;
      pc3_q <= '0;
    end else if (histShift) begin
      pc1_q <= pc_q;
      pc2_q <= pc1_q;
      pc3_q <= pc2_q;
    end
  end

  // Performance cycle counter.
  // It counts every RUN and DRAIN cycle after reset release.
  // It wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cntEn) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule
